// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, line levels and default bit timing.
// Used by the transmitter today and intended for the receiver as well.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL           = 1'b1;
    localparam logic UART_START_LEVEL          = 1'b0;
    localparam int   UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high so a new frame always starts on a fresh bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int             W    = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0]   LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    // Wrap back to zero on the terminal count so consecutive bits line up exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || bit_done) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: one byte per valid/ready handshake, sent as start/data/stop, LSB first.
// The serial line comes straight from a flop so the far-end synchronizer never sees a glitch.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int            IW       = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    tx_state_t              state;
    tx_state_t              state_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_next;
    logic [IW-1:0]          bit_idx;
    logic [IW-1:0]          idx_next;
    logic                   tx_next;
    logic                   bit_done;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx is computed from the next state so the line changes on the same edge as the state.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        idx_next   = bit_idx;
        tx_next    = UART_IDLE_LEVEL;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shift_next = tx_data;
                    idx_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + IW'(1);
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = UART_START_LEVEL;
            DATA:    tx_next = shift_next[0];
            default: tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_idx   <= '0;
            tx        <= UART_IDLE_LEVEL;
        end else begin
            shift_reg <= shift_next;
            bit_idx   <= idx_next;
            tx        <= tx_next;
        end
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT = 4, with an 8-bit and a 5-bit instance.
// Expected frames are written out by hand, one entry per bit slot.
module tb_uart_tx_serializer;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;

    logic [7:0] tx_data8;
    logic       tx_valid8;
    logic       tx_ready8;
    logic       tx8;
    logic       busy8;

    logic [4:0] tx_data5;
    logic       tx_valid5;
    logic       tx_ready5;
    logic       tx5;
    logic       busy5;

    int total = 0;
    int bad   = 0;

    always #5 if (clk_en) clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data8),
        .tx_valid(tx_valid8),
        .tx_ready(tx_ready8),
        .tx      (tx8),
        .busy    (busy8)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(5)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data5),
        .tx_valid(tx_valid5),
        .tx_ready(tx_ready5),
        .tx      (tx5),
        .busy    (busy5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] d);
        tx_data8  = d;
        tx_valid8 = 1'b1;
        tick();
        tx_valid8 = 1'b0;
    endtask

    // Records n cycles of outputs; optionally pulses tx_valid8 at sample pulse_at.
    task automatic capture(input int n, input int pulse_at, input logic [7:0] pulse_data,
                           output logic [63:0] t8, output logic [63:0] b8,
                           output logic [63:0] t5, output logic [63:0] b5);
        t8 = '0; b8 = '0; t5 = '0; b5 = '0;
        for (int i = 0; i < n; i++) begin
            if (i == pulse_at) begin
                tx_data8  = pulse_data;
                tx_valid8 = 1'b1;
            end else if (pulse_at >= 0) begin
                tx_valid8 = 1'b0;
            end
            t8[i] = tx8;
            b8[i] = busy8;
            t5[i] = tx5;
            b5[i] = busy5;
            tick();
        end
        if (pulse_at >= 0) tx_valid8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        total++; if (tx8 !== 1'b1)       begin bad++; $display("[TB] FAIL reset_tx8: got %b want 1", tx8); end
        total++; if (tx_ready8 !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready8: got %b want 1", tx_ready8); end
        total++; if (busy8 !== 1'b0)     begin bad++; $display("[TB] FAIL reset_busy8: got %b want 0", busy8); end
        total++; if (tx5 !== 1'b1)       begin bad++; $display("[TB] FAIL reset_tx5: got %b want 1", tx5); end
        total++; if (tx_ready5 !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready5: got %b want 1", tx_ready5); end
        total++; if (busy5 !== 1'b0)     begin bad++; $display("[TB] FAIL reset_busy5: got %b want 0", busy5); end
        clk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (tx8 !== 1'b1 || tx_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            bad++; $display("[TB] FAIL post_reset_idle: got tx=%b ready=%b busy=%b want 1 1 0", tx8, tx_ready8, busy8);
        end
    endtask

    task automatic test_single_frame();
        logic        exp [10];
        logic [63:0] t8, b8, t5, b5;
        exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        apply_stimulus(8'hA5);
        total++; if (tx_ready8 !== 1'b0) begin bad++; $display("[TB] FAIL single_ready_drop: got %b want 0", tx_ready8); end
        capture(40, -1, 8'h00, t8, b8, t5, b5);
        for (int i = 0; i < 40; i++) begin
            total++; if (t8[i] !== exp[i/4]) begin bad++; $display("[TB] FAIL single_tx[%0d]: got %b want %b", i, t8[i], exp[i/4]); end
            total++; if (b8[i] !== 1'b1) begin bad++; $display("[TB] FAIL single_busy[%0d]: got %b want 1", i, b8[i]); end
        end
        total++; if (tx_ready8 !== 1'b1) begin bad++; $display("[TB] FAIL single_ready_after: got %b want 1", tx_ready8); end
        total++; if (busy8 !== 1'b0)     begin bad++; $display("[TB] FAIL single_busy_after: got %b want 0", busy8); end
        total++; if (tx8 !== 1'b1)       begin bad++; $display("[TB] FAIL single_tx_after: got %b want 1", tx8); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic        exp0 [10];
        logic        expf [10];
        logic [63:0] t8, b8, t5, b5;
        exp0 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        expf = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tx_data8  = 8'h00;
        tx_valid8 = 1'b1;
        tick();
        tx_data8 = 8'hFF;
        capture(40, -1, 8'h00, t8, b8, t5, b5);
        for (int i = 0; i < 40; i++) begin
            total++; if (t8[i] !== exp0[i/4]) begin bad++; $display("[TB] FAIL b2b_first_tx[%0d]: got %b want %b", i, t8[i], exp0[i/4]); end
        end
        total++; if (tx8 !== 1'b1 || tx_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_gap: got tx=%b ready=%b busy=%b want 1 1 0", tx8, tx_ready8, busy8);
        end
        tick();
        tx_valid8 = 1'b0;
        capture(40, -1, 8'h00, t8, b8, t5, b5);
        for (int i = 0; i < 40; i++) begin
            total++; if (t8[i] !== expf[i/4]) begin bad++; $display("[TB] FAIL b2b_second_tx[%0d]: got %b want %b", i, t8[i], expf[i/4]); end
            total++; if (b8[i] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_busy[%0d]: got %b want 1", i, b8[i]); end
        end
        total++; if (tx_ready8 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_after: got %b want 1", tx_ready8); end
        tick();
    endtask

    task automatic test_valid_while_busy();
        logic        exp [10];
        logic [63:0] t8, b8, t5, b5;
        exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_stimulus(8'hC3);
        capture(40, 12, 8'h3C, t8, b8, t5, b5);
        for (int i = 0; i < 40; i++) begin
            total++; if (t8[i] !== exp[i/4]) begin bad++; $display("[TB] FAIL vwb_tx[%0d]: got %b want %b", i, t8[i], exp[i/4]); end
        end
        capture(45, -1, 8'h00, t8, b8, t5, b5);
        for (int i = 0; i < 45; i++) begin
            total++; if (t8[i] !== 1'b1 || b8[i] !== 1'b0) begin
                bad++; $display("[TB] FAIL vwb_no_second[%0d]: got tx=%b busy=%b want 1 0", i, t8[i], b8[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic        exp [10];
        logic [63:0] t8, b8, t5, b5;
        exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_stimulus(8'h81);
        capture(17, -1, 8'h00, t8, b8, t5, b5);
        total++; if (tx8 !== 1'b0 || busy8 !== 1'b1) begin
            bad++; $display("[TB] FAIL rmf_before: got tx=%b busy=%b want 0 1", tx8, busy8);
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (tx8 !== 1'b1)       begin bad++; $display("[TB] FAIL rmf_async_tx: got %b want 1", tx8); end
        total++; if (busy8 !== 1'b0)     begin bad++; $display("[TB] FAIL rmf_async_busy: got %b want 0", busy8); end
        total++; if (tx_ready8 !== 1'b1) begin bad++; $display("[TB] FAIL rmf_async_ready: got %b want 1", tx_ready8); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (tx8 !== 1'b1 || tx_ready8 !== 1'b1) begin
            bad++; $display("[TB] FAIL rmf_idle: got tx=%b ready=%b want 1 1", tx8, tx_ready8);
        end
        apply_stimulus(8'h81);
        capture(40, -1, 8'h00, t8, b8, t5, b5);
        for (int i = 0; i < 40; i++) begin
            total++; if (t8[i] !== exp[i/4]) begin bad++; $display("[TB] FAIL rmf_resend_tx[%0d]: got %b want %b", i, t8[i], exp[i/4]); end
        end
        total++; if (tx_ready8 !== 1'b1) begin bad++; $display("[TB] FAIL rmf_ready_after: got %b want 1", tx_ready8); end
        tick();
    endtask

    task automatic test_width_sweep();
        logic        exp [7];
        logic [63:0] t8, b8, t5, b5;
        exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tx_data5  = 5'h15;
        tx_valid5 = 1'b1;
        tick();
        tx_valid5 = 1'b0;
        capture(28, -1, 8'h00, t8, b8, t5, b5);
        for (int i = 0; i < 28; i++) begin
            total++; if (t5[i] !== exp[i/4]) begin bad++; $display("[TB] FAIL w5_tx[%0d]: got %b want %b", i, t5[i], exp[i/4]); end
            total++; if (b5[i] !== 1'b1) begin bad++; $display("[TB] FAIL w5_busy[%0d]: got %b want 1", i, b5[i]); end
        end
        total++; if (busy5 !== 1'b0)     begin bad++; $display("[TB] FAIL w5_busy_after: got %b want 0", busy5); end
        total++; if (tx_ready5 !== 1'b1) begin bad++; $display("[TB] FAIL w5_ready_after: got %b want 1", tx_ready5); end
        total++; if (tx5 !== 1'b1)       begin bad++; $display("[TB] FAIL w5_tx_after: got %b want 1", tx5); end
    endtask

    initial begin
        tx_data8  = 8'h00;
        tx_valid8 = 1'b0;
        tx_data5  = 5'h00;
        tx_valid5 = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_valid_while_busy();
        test_reset_mid_frame();
        test_width_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
